// File: rtl/ahb_bm_pkg.sv
// Shared AHB encodings and the address-phase bundle used by the input stages and arbiters.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HburstSingle = 3'b000,
    HburstIncr   = 3'b001,
    HburstWrap4  = 3'b010,
    HburstIncr4  = 3'b011,
    HburstWrap8  = 3'b100,
    HburstIncr8  = 3'b101,
    HburstWrap16 = 3'b110,
    HburstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
  } addr_phase_t;

  localparam addr_phase_t AddrPhaseReset = '0;

endpackage

// File: rtl/ahb_input_stage_if.sv
// Master-side AHB port plus the arbiter/decoder side of one bus-matrix input stage.
interface ahb_input_stage_if;

  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;

  logic [31:0] ADDRI;
  logic [1:0]  TRANSI;
  logic        WRITEI;
  logic [2:0]  SIZEI;
  logic [2:0]  BURSTI;
  logic [3:0]  PROTI;
  logic        MASTLOCKI;
  logic        active_trans;
  logic        addr_in_phase;
  logic        data_in_phase;
  logic        HREADYM;
  logic        HRESPM;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS,
    output ADDRI, TRANSI, WRITEI, SIZEI, BURSTI, PROTI, MASTLOCKI, active_trans,
    input  addr_in_phase, data_in_phase, HREADYM, HRESPM
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS,
    input  ADDRI, TRANSI, WRITEI, SIZEI, BURSTI, PROTI, MASTLOCKI, active_trans,
    output addr_in_phase, data_in_phase, HREADYM, HRESPM
  );

endinterface

// File: rtl/ahb_addr_hold_reg.sv
// Holding register for a stalled address phase and the held/live output mux.
module ahb_addr_hold_reg
  import ahb_bm_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        load,
  input  logic        use_held,
  input  addr_phase_t live,
  output addr_phase_t phase
);

  addr_phase_t held_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      held_q <= AddrPhaseReset;
    end else if (load) begin
      held_q <= live;
    end
  end

  always_comb begin
    phase = use_held ? held_q : live;
  end

endmodule

// File: rtl/ahb_input_stage.sv
// Bus-matrix input stage: passes the master address phase to the arbiters and holds it
// for as long as no arbiter grants it, stalling the master meanwhile.
module ahb_input_stage
  import ahb_bm_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_input_stage_if.slave   bus
);

  logic        valid;
  logic        accepted;
  logic        load;
  logic        reg_pend_q;
  logic        reg_pend_d;
  addr_phase_t live;
  addr_phase_t phase;

  assign valid    = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign accepted = bus.addr_in_phase & bus.HREADYM;

  always_comb begin
    live.addr     = bus.HADDRS;
    live.trans    = bus.HTRANSS;
    live.write    = bus.HWRITES;
    live.size     = bus.HSIZES;
    live.burst    = bus.HBURSTS;
    live.prot     = bus.HPROTS;
    live.mastlock = bus.HMASTLOCKS;
  end

  // A transfer arriving in the cycle the held one is granted takes its place in the register.
  always_comb begin
    reg_pend_d = reg_pend_q;
    load       = 1'b0;
    if (reg_pend_q) begin
      if (accepted) begin
        reg_pend_d = valid;
        load       = valid;
      end
    end else if (valid && !accepted) begin
      reg_pend_d = 1'b1;
      load       = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      reg_pend_q <= 1'b0;
    end else begin
      reg_pend_q <= reg_pend_d;
    end
  end

  ahb_addr_hold_reg u_hold (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .load     (load),
    .use_held (reg_pend_q),
    .live     (live),
    .phase    (phase)
  );

  always_comb begin
    bus.active_trans = reg_pend_q | valid;
    bus.ADDRI        = phase.addr;
    bus.TRANSI       = bus.active_trans ? phase.trans : HtransIdle;
    bus.WRITEI       = phase.write;
    bus.SIZEI        = phase.size;
    bus.BURSTI       = phase.burst;
    bus.PROTI        = phase.prot;
    bus.MASTLOCKI    = phase.mastlock;

    if (bus.data_in_phase) begin
      bus.HREADYOUTS = bus.HREADYM;
    end else begin
      bus.HREADYOUTS = ~reg_pend_q;
    end
    bus.HRESPS = bus.data_in_phase ? bus.HRESPM : HrespOkay;
  end

endmodule

// File: tb/tb_ahb_input_stage.sv
// Directed self-checking bench for ahb_input_stage.
module tb_ahb_input_stage;

  logic HCLK;
  logic HRESET;
  int   total = 0;
  int   bad   = 0;

  ahb_input_stage_if bus ();

  ahb_input_stage dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    bus.HSELS         = 1'b0;
    bus.HADDRS        = 32'h0;
    bus.HTRANSS       = 2'b00;
    bus.HWRITES       = 1'b0;
    bus.HSIZES        = 3'd0;
    bus.HBURSTS       = 3'd0;
    bus.HPROTS        = 4'h0;
    bus.HMASTLOCKS    = 1'b0;
    bus.HREADYS       = 1'b1;
    bus.addr_in_phase = 1'b0;
    bus.data_in_phase = 1'b0;
    bus.HREADYM       = 1'b1;
    bus.HRESPM        = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b);
    bus.HSELS   = 1'b1;
    bus.HADDRS  = a;
    bus.HTRANSS = t;
    bus.HBURSTS = b;
    bus.HSIZES  = 3'd2;
    bus.HPROTS  = 4'h3;
    bus.HREADYS = 1'b1;
  endtask

  initial begin
    // Reset state
    HRESET = 1'b1;
    idle_in();
    #1;
    chk("rst_active", bus.active_trans, 0);
    chk("rst_rdy", bus.HREADYOUTS, 1);
    chk("rst_resp", bus.HRESPS, 0);
    chk("rst_trans", bus.TRANSI, 0);
    chk("rst_pend", dut.reg_pend_q, 0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Zero-latency pass-through
    drive(32'h1000, 2'b10, 3'b000);
    bus.addr_in_phase = 1'b1;
    #1;
    chk("pt_addr", bus.ADDRI, 32'h1000);
    chk("pt_trans", bus.TRANSI, 2);
    chk("pt_active", bus.active_trans, 1);
    chk("pt_rdy", bus.HREADYOUTS, 1);
    tick();
    idle_in();
    #1;
    chk("pt_pend", dut.reg_pend_q, 0);

    // IDLE and BUSY with HSELS=1 never request
    bus.HSELS = 1'b1;
    bus.HTRANSS = 2'b00;
    bus.HADDRS = 32'h4444;
    #1;
    chk("idle_active", bus.active_trans, 0);
    chk("idle_rdy", bus.HREADYOUTS, 1);
    chk("idle_resp", bus.HRESPS, 0);
    chk("idle_trans", bus.TRANSI, 0);
    tick();
    bus.HTRANSS = 2'b01;
    #1;
    chk("busy_active", bus.active_trans, 0);
    chk("busy_rdy", bus.HREADYOUTS, 1);
    chk("busy_trans", bus.TRANSI, 0);
    tick();
    chk("busy_pend", dut.reg_pend_q, 0);

    // Three-cycle arbiter stall
    idle_in();
    drive(32'h2000, 2'b10, 3'b000);
    bus.HWRITES = 1'b1;
    #1;
    chk("st0_rdy", bus.HREADYOUTS, 1);
    chk("st0_active", bus.active_trans, 1);
    tick();
    bus.HREADYS = 1'b0;
    bus.HADDRS  = 32'hDEAD0000;
    bus.HWRITES = 1'b0;
    #1;
    chk("st1_rdy", bus.HREADYOUTS, 0);
    chk("st1_addr", bus.ADDRI, 32'h2000);
    chk("st1_write", bus.WRITEI, 1);
    chk("st1_trans", bus.TRANSI, 2);
    chk("st1_active", bus.active_trans, 1);
    chk("st1_pend", dut.reg_pend_q, 1);
    tick();
    chk("st2_rdy", bus.HREADYOUTS, 0);
    chk("st2_addr", bus.ADDRI, 32'h2000);
    tick();
    bus.addr_in_phase = 1'b1;
    #1;
    chk("st3_rdy", bus.HREADYOUTS, 0);
    chk("st3_addr", bus.ADDRI, 32'h2000);
    tick();
    idle_in();
    #1;
    chk("st4_pend", dut.reg_pend_q, 0);
    chk("st4_rdy", bus.HREADYOUTS, 1);
    chk("st4_active", bus.active_trans, 0);
    chk("st4_trans", bus.TRANSI, 0);

    // INCR4 burst, beat 2 stalled for one cycle
    drive(32'h3000, 2'b10, 3'b011);
    bus.addr_in_phase = 1'b1;
    #1;
    chk("b1_addr", bus.ADDRI, 32'h3000);
    tick();
    drive(32'h3004, 2'b11, 3'b011);
    bus.addr_in_phase = 1'b0;
    #1;
    chk("b2_live_addr", bus.ADDRI, 32'h3004);
    chk("b2_live_rdy", bus.HREADYOUTS, 1);
    tick();
    bus.HREADYS = 1'b0;
    bus.HADDRS  = 32'hBAD0;
    bus.addr_in_phase = 1'b1;
    #1;
    chk("b2_held_addr", bus.ADDRI, 32'h3004);
    chk("b2_held_trans", bus.TRANSI, 3);
    chk("b2_held_burst", bus.BURSTI, 3);
    chk("b2_held_rdy", bus.HREADYOUTS, 0);
    chk("b2_held_pend", dut.reg_pend_q, 1);
    tick();
    drive(32'h3008, 2'b11, 3'b011);
    #1;
    chk("b3_addr", bus.ADDRI, 32'h3008);
    chk("b3_pend", dut.reg_pend_q, 0);
    chk("b3_rdy", bus.HREADYOUTS, 1);
    tick();
    drive(32'h300C, 2'b11, 3'b011);
    #1;
    chk("b4_addr", bus.ADDRI, 32'h300C);
    tick();
    idle_in();
    #1;
    chk("b_end_pend", dut.reg_pend_q, 0);

    // New transfer arriving in the cycle the held one is granted
    drive(32'h5000, 2'b10, 3'b000);
    tick();
    drive(32'h6000, 2'b10, 3'b000);
    bus.data_in_phase = 1'b1;
    bus.addr_in_phase = 1'b1;
    #1;
    chk("bb_old_addr", bus.ADDRI, 32'h5000);
    chk("bb_rdy", bus.HREADYOUTS, 1);
    tick();
    idle_in();
    bus.addr_in_phase = 1'b1;
    #1;
    chk("bb_pend", dut.reg_pend_q, 1);
    chk("bb_new_addr", bus.ADDRI, 32'h6000);
    chk("bb_new_trans", bus.TRANSI, 2);
    tick();
    chk("bb_clear", dut.reg_pend_q, 0);
    idle_in();

    // Illegal transfer while pending is not captured; reset discards the hold
    drive(32'h7000, 2'b10, 3'b000);
    tick();
    drive(32'h8000, 2'b10, 3'b000);
    #1;
    chk("ill_addr0", bus.ADDRI, 32'h7000);
    tick();
    bus.HSELS = 1'b0;
    #1;
    chk("ill_addr1", bus.ADDRI, 32'h7000);
    chk("ill_pend", dut.reg_pend_q, 1);
    chk("ill_active", bus.active_trans, 1);
    chk("ill_rdy", bus.HREADYOUTS, 0);
    HRESET = 1'b1;
    #1;
    chk("arst_active", bus.active_trans, 0);
    chk("arst_rdy", bus.HREADYOUTS, 1);
    chk("arst_trans", bus.TRANSI, 0);
    chk("arst_pend", dut.reg_pend_q, 0);
    tick();
    HRESET = 1'b0;
    idle_in();

    // Two-cycle ERROR response
    bus.data_in_phase = 1'b1;
    bus.HRESPM = 1'b1;
    bus.HREADYM = 1'b0;
    #1;
    chk("err1_resp", bus.HRESPS, 1);
    chk("err1_rdy", bus.HREADYOUTS, 0);
    tick();
    bus.HREADYM = 1'b1;
    #1;
    chk("err2_resp", bus.HRESPS, 1);
    chk("err2_rdy", bus.HREADYOUTS, 1);
    tick();
    bus.data_in_phase = 1'b0;
    #1;
    chk("err_done_resp", bus.HRESPS, 0);
    chk("err_done_rdy", bus.HREADYOUTS, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_input_stage.md
AHB_INPUT_STAGE -- requirements
Module: ahb_input_stage

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 HCLK  input  1  AHB system clock; all state on rising edge.
REQ-003 HRESET  input  1  asynchronous, active-high reset.
REQ-004 HSELS, HADDRS[31:0], HTRANSS[1:0], HWRITES, HSIZES[2:0], HBURSTS[2:0], HPROTS[3:0], HMASTLOCKS  input  master-side address phase.
REQ-005 HREADYS  input  1  master-side bus HREADY.
REQ-006 HREADYOUTS  output  1  ready returned to master.
REQ-007 HRESPS  output  1  response returned to master (0 OKAY, 1 ERROR).
REQ-008 ADDRI[31:0], TRANSI[1:0], WRITEI, SIZEI[2:0], BURSTI[2:0], PROTI[3:0], MASTLOCKI  output  address phase presented to the output arbiters and decoders.
REQ-009 active_trans  output  1  request to output arbiters (drives req_portN).
REQ-010 addr_in_phase  input  1  an arbiter has granted this port's address phase this cycle.
REQ-011 data_in_phase  input  1  this port owns a slave data phase.
REQ-012 HREADYM, HRESPM  input  1 each  ready/response from the owning slave.

Function
REQ-013 Valid transfer: HSELS & HTRANSS[1] & HREADYS.
REQ-014 The block SHALL hold one pending flag (reg_pend) plus a holding register for all REQ-004 fields except HSELS.
REQ-015 On a valid transfer with addr_in_phase=0, the holding register SHALL load and reg_pend SHALL set next cycle.
REQ-016 While reg_pend=1, holding register SHALL NOT load; REQ-008 outputs SHALL drive held values; otherwise they drive live master values.
REQ-017 reg_pend SHALL clear on the cycle addr_in_phase=1 and HREADYM=1 (address phase accepted).
REQ-018 active_trans = reg_pend | (HSELS & HTRANSS[1] & HREADYS); BUSY and IDLE never request.
REQ-019 TRANSI SHALL read IDLE (00) when active_trans=0.
REQ-020 HREADYOUTS: data_in_phase=1 -> HREADYM; else reg_pend=1 -> 0; else 1.
REQ-021 HRESPS: data_in_phase=1 -> HRESPM; else 0.
REQ-022 ERROR is two cycles (HRESPM=1, HREADYM 0 then 1); both cycles SHALL pass unmodified while data_in_phase=1.
REQ-023 Zero-wait OKAY SHALL be returned to the master for IDLE/BUSY and for unselected cycles.
REQ-024 Simultaneous: valid transfer with addr_in_phase=1 and HREADYM=1 -> no hold, reg_pend stays 0 (zero-latency pass-through).
REQ-025 Valid transfer while reg_pend=1 is illegal (HREADYOUTS=0 blocks it); no capture.
REQ-026 Back-to-back: pending accepted in same cycle a new valid transfer arrives -> new transfer loads holding register only if addr_in_phase for it is 0 on following cycle (REQ-015 applies per cycle).
REQ-027 Added latency SHALL be zero when ungranted-free; at most one wait state per arbiter-induced stall cycle.

Reset
REQ-028 On HRESET: reg_pend=0, holding register all 0 (TRANS=IDLE), so active_trans=0, HREADYOUTS=1, HRESPS=0, TRANSI=00.
REQ-029 HRESET asserted mid-hold SHALL discard the pending transfer immediately (asynchronous).

Structure
REQ-030 HTRANS/HBURST encodings (IDLE, BUSY, NONSEQ, SEQ; SINGLE..INCR16) and HRESP codes SHALL live in shared package ahb_bm_pkg, reused by the arbiters.
REQ-031 Holding register plus its mux SHALL be one sub-module, ahb_addr_hold_reg; remaining logic flat.

Verification
REQ-032 Pass-through: NONSEQ 0x1000 with addr_in_phase=1, HREADYM=1 -> ADDRI=0x1000 same cycle, reg_pend=0, HREADYOUTS=1.
REQ-033 Stall: NONSEQ 0x2000 with addr_in_phase=0 for 3 cycles -> HREADYOUTS=0 three cycles, ADDRI holds 0x2000, active_trans=1; grant -> reg_pend clears next cycle.
REQ-034 INCR4 burst 0x3000..0x300C granted mid-burst after one-cycle stall on beat 2 -> beat 2 held as SEQ 0x3004, all four beats delivered in order.
REQ-035 Error: data_in_phase=1, HRESPM=1/HREADYM=0 then 1/1 -> HRESPS=1 both cycles, HREADYOUTS 0 then 1.
REQ-036 IDLE and BUSY cycles with HSELS=1 -> active_trans=0, HREADYOUTS=1, HRESPS=0.
REQ-037 HRESET asserted while reg_pend=1 -> active_trans=0 and HREADYOUTS=1 without a clock edge.
